// File: rtl/data_stack.sv
// data_stack: operand stack for the stack machine.
//
// TOS and NEXT live in dedicated registers that feed the ALU directly.
// Deeper entries spill into a register array (combinational read). Every
// op (push, pop, dup, ALU write-back) completes in a single clock.
//
// Optional feature macro: DATA_STACK_GUARD_EN
//   defined   : overflowing/underflowing ops are suppressed and raise sticky
//               o_overflow / o_underflow flags (cleared only by reset).
//   undefined : no checking, flags tied to 0, counters wrap.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   op          3'b000 NOP, 001 PUSH, 010 POP, 011 ALU_KEEP, 100 ALU_POP,
//               101 DUP, 110/111 NOP
//   din         word to push
//   alu_tos     ALU o_tos result (sampled with ALU_KEEP / ALU_POP)
//   alu_next    ALU o_next result (sampled with ALU_KEEP)
//   o_tos       top-of-stack register
//   o_next      next-on-stack register
//   o_depth     number of valid items, 0..DEPTH+2
//   o_empty     o_depth == 0
//   o_full      o_depth == DEPTH+2
//   o_overflow  sticky overflow flag
//   o_underflow sticky underflow flag
module data_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   op,
  input  logic [WIDTH-1:0]             din,
  input  logic [WIDTH-1:0]             alu_tos,
  input  logic [WIDTH-1:0]             alu_next,
  output logic [WIDTH-1:0]             o_tos,
  output logic [WIDTH-1:0]             o_next,
  output logic [$clog2(DEPTH+3)-1:0]   o_depth,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int CW = $clog2(DEPTH+3);
  localparam int SW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH+2);
  localparam logic [SW-1:0] SP_LIMIT = SW'(DEPTH);

  localparam logic [2:0] OP_PUSH     = 3'b001;
  localparam logic [2:0] OP_POP      = 3'b010;
  localparam logic [2:0] OP_ALU_KEEP = 3'b011;
  localparam logic [2:0] OP_ALU_POP  = 3'b100;
  localparam logic [2:0] OP_DUP      = 3'b101;

  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] next_q, next_d;
  logic [SW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             spill_en;
  logic [SW-1:0]    sp_dec;
  logic [WIDTH-1:0] refill_val;
  logic             block;

  // Word that moves up into NEXT when the stack shrinks. An empty spill
  // store yields 0 so a vacated NEXT never exposes a stale entry.
  assign sp_dec     = sp_q - SW'(1);
  assign refill_val = ((sp_q != '0) && (sp_dec < SP_LIMIT)) ? mem[AW'(sp_dec)] : '0;

`ifdef DATA_STACK_GUARD_EN
  logic ovf_req, unf_req;
  logic ovf_q, unf_q;

  assign ovf_req = ((op == OP_PUSH) || (op == OP_DUP)) && (count_q == CNT_FULL);
  assign unf_req = (((op == OP_POP) || (op == OP_DUP)) && (count_q == '0)) ||
                   (((op == OP_ALU_KEEP) || (op == OP_ALU_POP)) && (count_q < CW'(2)));
  assign block   = ovf_req || unf_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_req) ovf_q <= 1'b1;
      if (unf_req) unf_q <= 1'b1;
    end
  end

  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
`else
  assign block       = 1'b0;
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

  always_comb begin
    tos_d    = tos_q;
    next_d   = next_q;
    sp_d     = sp_q;
    count_d  = count_q;
    spill_en = 1'b0;
    if (!block) begin
      case (op)
        OP_PUSH, OP_DUP: begin
          // With fewer than two items NEXT is empty, so TOS just slides
          // down into it and the spill store is left alone.
          if (count_q >= CW'(2)) begin
            spill_en = (sp_q < SP_LIMIT);
            sp_d     = sp_q + SW'(1);
          end
          next_d  = tos_q;
          tos_d   = (op == OP_DUP) ? tos_q : din;
          count_d = count_q + CW'(1);
        end
        OP_POP: begin
          tos_d   = next_q;
          next_d  = refill_val;
          if (sp_q != '0) sp_d = sp_dec;
          count_d = count_q - CW'(1);
        end
        OP_ALU_KEEP: begin
          tos_d  = alu_tos;
          next_d = alu_next;
        end
        OP_ALU_POP: begin
          tos_d   = alu_tos;
          next_d  = refill_val;
          if (sp_q != '0) sp_d = sp_dec;
          count_d = count_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_q   <= '0;
      next_q  <= '0;
      sp_q    <= '0;
      count_q <= '0;
    end else begin
      tos_q   <= tos_d;
      next_q  <= next_d;
      sp_q    <= sp_d;
      count_q <= count_d;
    end
  end

  // Spill store has no reset; entries above sp are never read back.
  always_ff @(posedge clk) begin
    if (spill_en && rst_n) mem[AW'(sp_q)] <= next_q;
  end

  assign o_tos   = tos_q;
  assign o_next  = next_q;
  assign o_depth = count_q;
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CNT_FULL);

endmodule

// File: tb/tb_data_stack.sv
// Testbench for data_stack (DEPTH=4, WIDTH=16): directed scenarios plus
// constrained-random ops; a queue-based stack model supplies expectations
// and a monitor compares the DUT after each clock edge.
module tb_data_stack;

  localparam int W   = 16;
  localparam int D   = 4;
  localparam int CAP = D + 2;

  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010,
                         KEEP = 3'b011, APOP = 3'b100, DUP = 3'b101;

`ifdef DATA_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [2:0]         op;
  logic [W-1:0]       din, alu_tos, alu_next;
  logic [W-1:0]       o_tos, o_next;
  logic [$clog2(D+3)-1:0] o_depth;
  logic               o_empty, o_full, o_overflow, o_underflow;

  data_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .din(din),
    .alu_tos(alu_tos), .alu_next(alu_next),
    .o_tos(o_tos), .o_next(o_next), .o_depth(o_depth),
    .o_empty(o_empty), .o_full(o_full),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] tos;
    logic [W-1:0] nxt;
    int           depth;
    bit           ovf;
    bit           unf;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] st[$];
  bit           m_ovf, m_unf;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    int n = st.size();
    e.tos   = (n >= 1) ? st[n-1] : '0;
    e.nxt   = (n >= 2) ? st[n-2] : '0;
    e.depth = n;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  function automatic bit legal(input logic [2:0] o);
    int n = st.size();
    case (o)
      PUSH:       return n < CAP;
      DUP:        return (n > 0) && (n < CAP);
      POP:        return n > 0;
      KEEP, APOP: return n >= 2;
      default:    return 1'b1;
    endcase
  endfunction

  // Abstract stack semantics: the queue's last element is the top.
  task automatic model_apply(input logic [2:0] o, input logic [W-1:0] d,
                             input logic [W-1:0] at, input logic [W-1:0] an);
    int n = st.size();
    if (!legal(o)) begin
      if ((o == PUSH || o == DUP) && n == CAP) m_ovf = 1'b1;
      else                                     m_unf = 1'b1;
    end else begin
      case (o)
        PUSH: st.push_back(d);
        DUP:  st.push_back(st[n-1]);
        POP:  void'(st.pop_back());
        KEEP: begin st[n-1] = at; st[n-2] = an; end
        APOP: begin void'(st.pop_back()); st[n-2] = at; end
        default: ;
      endcase
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] d,
                       input logic [W-1:0] at, input logic [W-1:0] an);
    @(negedge clk);
    op = o; din = d; alu_tos = at; alu_next = an;
    model_apply(o, d, at, an);
    exp_q.push_back(snapshot());
  endtask

  task automatic do_reset();
    @(negedge clk);
    op = NOP;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tos",   o_tos,       0);
    chk("rst_next",  o_next,      0);
    chk("rst_depth", o_depth,     0);
    chk("rst_empty", o_empty,     1);
    chk("rst_full",  o_full,      0);
    chk("rst_ovf",   o_overflow,  0);
    chk("rst_unf",   o_underflow, 0);
    st.delete(); m_ovf = 1'b0; m_unf = 1'b0; exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one expected state per op, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("tos",   o_tos,       e.tos);
      chk("next",  o_next,      e.nxt);
      chk("depth", o_depth,     e.depth);
      chk("empty", o_empty,     e.depth == 0);
      chk("full",  o_full,      e.depth == CAP);
      chk("ovf",   o_overflow,  e.ovf);
      chk("unf",   o_underflow, e.unf);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] o;
    int r;
    rst_n = 1'b0; op = NOP; din = '0; alu_tos = '0; alu_next = '0;
    m_ovf = 1'b0; m_unf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream
    do_op(PUSH, 16'h00AA, '0, '0);
    do_reset();

    // Push/pop order
    do_op(PUSH, 16'h0001, '0, '0);
    do_op(PUSH, 16'h0002, '0, '0);
    do_op(PUSH, 16'h0003, '0, '0);
    repeat (3) do_op(POP, '0, '0, '0);

    // ALU_POP refill from the spill store
    do_reset();
    do_op(PUSH, 16'h1234, '0, '0);
    do_op(PUSH, 16'hFFFF, '0, '0);
    do_op(PUSH, 16'h003F, '0, '0);
    do_op(APOP, '0, 16'h003E, 16'h5A5A);

    // Swap via ALU_KEEP
    do_reset();
    do_op(PUSH, 16'h0F0F, '0, '0);
    do_op(PUSH, 16'hCCCC, '0, '0);
    do_op(KEEP, '0, 16'h0F0F, 16'hCCCC);

    // Fill to capacity, then drain in LIFO order
    do_reset();
    for (int i = 1; i <= CAP; i++) do_op(PUSH, W'(i), '0, '0);
`ifdef DATA_STACK_GUARD_EN
    do_op(PUSH, 16'h0007, '0, '0);
`endif
    repeat (CAP) do_op(POP, '0, '0, '0);

`ifdef DATA_STACK_GUARD_EN
    // Underflow cases
    do_reset();
    do_op(POP, '0, '0, '0);
    do_reset();
    do_op(PUSH, 16'h0055, '0, '0);
    do_op(APOP, '0, 16'h9999, 16'h8888);
    do_reset();
    do_op(DUP, '0, '0, '0);
`endif

    // Random ops against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: o = PUSH;
        3, 4:    o = POP;
        5:       o = KEEP;
        6:       o = APOP;
        7:       o = DUP;
        8:       o = NOP;
        default: o = 3'($urandom_range(6, 7));
      endcase
      if (!GUARD && !legal(o)) o = NOP;
      do_op(o, W'($urandom), W'($urandom), W'($urandom));
    end

    @(negedge clk);
    op = NOP;
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_stack.md
# data_stack

Operand stack for the stack machine: holds top-of-stack (TOS) and next-on-stack (NEXT) in dedicated registers and spills deeper entries into a register-array store. It sits directly upstream of the ALU, driving the ALU's `tos`/`next` operands and writing back the ALU's `o_tos`/`o_next` results. Push, pop, dup and ALU write-back each complete in one clock. Depth, full and empty status are exported to the control unit.

## Interface
- `WIDTH`, 16: data word width, matching the ALU operands.
- `DEPTH`, 16: spill-store entries below NEXT. Total capacity is DEPTH+2. Must be at least 2.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  3  operation select:
  - 000 NOP
  - 001 PUSH
  - 010 POP
  - 011 ALU_KEEP
  - 100 ALU_POP
  - 101 DUP
  - 110/111 treated as NOP
- `din`  in  WIDTH  word to push.
- `alu_tos`  in  WIDTH  ALU `o_tos` result.
- `alu_next`  in  WIDTH  ALU `o_next` result.
- `o_tos`  out  WIDTH  TOS register; feeds ALU `tos`.
- `o_next`  out  WIDTH  NEXT register; feeds ALU `next`.
- `o_depth`  out  $clog2(DEPTH+3)  number of valid items, 0..DEPTH+2.
- `o_empty`  out  1  o_depth==0.
- `o_full`  out  1  o_depth==DEPTH+2.
- `o_overflow`  out  1  sticky error flag; see Configuration.
- `o_underflow`  out  1  sticky error flag; see Configuration.

## Operation
- State:
  - `tos`, `next`
  - `mem[0..DEPTH-1]`, a register array with combinational read
  - `sp`, spill occupancy 0..DEPTH
  - `count`, driving o_depth
- PUSH:
  - mem[sp]←next, sp+1, but only when count≥2; otherwise no spill.
  - next←tos, tos←din, count+1.
- DUP: same as PUSH, with din replaced by tos.
- POP:
  - tos←next.
  - next←mem[sp-1] and sp-1 when sp>0; otherwise next←0.
  - count-1.
- ALU_KEEP:
  - tos←alu_tos, next←alu_next.
  - count unchanged.
  - Used for unary ops and swap.
- ALU_POP:
  - tos←alu_tos.
  - next←mem[sp-1] and sp-1 when sp>0; otherwise next←0.
  - count-1.
  - Used for binary ops that consume NEXT.
- A vacated NEXT or TOS always reads 0. Stale spill entries are never exposed.
- Precondition for ALU_KEEP and ALU_POP: count≥2.
- The ALU is combinational on o_tos/o_next, so alu_tos/alu_next are sampled in the same cycle the ALU op is issued.

## Timing
- Every update happens on the rising clk edge. Outputs are registered; new values are visible one cycle after the op is sampled.
- Latency: one cycle for every op. Ops may issue back-to-back every cycle with no stall.
- Asynchronous reset: rst_n low immediately forces the following, regardless of clock:
  - o_tos=0, o_next=0, o_depth=0
  - o_empty=1, o_full=0
  - o_overflow=0, o_underflow=0
  - sp=0
- mem contents are not reset.
- Reset asserted mid-operation discards the in-flight op.
- Boundary conditions:
  - PUSH or DUP with count==DEPTH+2 is an overflow.
  - DUP with count==0 is an underflow.
  - POP with count==0 is an underflow.
  - ALU_KEEP or ALU_POP with count<2 is an underflow.
- A PUSH when count==1 moves TOS into NEXT without touching mem.

## Configuration
- Macro: `DATA_STACK_GUARD_EN`.
- Defined:
  - Overflowing or underflowing ops are suppressed; all state is unchanged.
  - The matching sticky flag sets and stays set until reset.
- Undefined:
  - No checking; o_overflow and o_underflow are tied to 0.
  - sp and count wrap modulo their width.
  - State after an illegal op is unspecified and not verified.

## Test plan
All cases use DEPTH=4, WIDTH=16.
- Reset mid-stream: push 0x00AA, then drop rst_n between edges → o_tos=0, o_next=0, o_depth=0, o_empty=1 without waiting for a clock edge.
- Push/pop order: PUSH 0x0001, 0x0002, 0x0003 → o_tos=3, o_next=2, depth 3. Three POPs → o_tos 2, then 1, then 0; depth 0; o_next=0 throughout the tail.
- ALU_POP refill: PUSH 0x1234, 0xFFFF, 0x003F; then ALU_POP with alu_tos=0x003E → o_tos=0x003E, o_next=0x1234, depth 2.
- Swap via ALU_KEEP: tos=0xCCCC, next=0x0F0F; ALU_KEEP with alu_tos=0x0F0F, alu_next=0xCCCC → outputs swapped, depth unchanged.
- Full and overflow (guard defined): PUSH 1..6 → o_full=1. A 7th PUSH of 0x0007 → o_overflow=1, o_tos=6, depth 6. Six POPs then return 6,5,4,3,2,1 in order.
- Underflow (guard defined): POP on empty → o_underflow=1, depth 0. ALU_POP with depth 1 → o_underflow=1, o_tos unchanged.
